// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions for the sequencer and the PC block.
// Holds the sequencer state encoding and the exit address constant.
// No logic; types and constants only.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // Address at which the PC block raises finish.
  localparam logic [31:0] EXIT_ADDR = 32'h0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Count updates one cycle after en/clr; clear has priority over enable.
// No backpressure; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up when enabled, stick at all-ones, clear on request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// FETCH/EXEC sequencer: stretches phases on memory/muldiv stalls, emits commit.
// Strobes are combinational from state and inputs; bus_error/cycle_count registered.
// Stalls hold the current phase; optional timeout halts the core with bus_error.
module exec_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        finish,
  input  logic        imem_wait,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_wait,
  input  logic        muldiv_busy,
  input  logic        ctrl_reg_write,
  output logic        imem_read,
  output logic        ir_load,
  output logic        dmem_en,
  output logic        commit,
  output logic        reg_write_en,
  output logic        active,
  output logic        bus_error,
  output logic [31:0] cycle_count
);

  seq_state_t  state;
  seq_state_t  state_nxt;
  logic        dmem_any;
  logic        stall_cond;
  logic        stall_cycle;
  logic        timeout;
  logic        imem_read_c;
  logic        ir_load_c;
  logic        dmem_en_c;
  logic        commit_c;
  logic        bus_error_q;
  logic [31:0] wait_cnt;

  assign dmem_any   = dmem_read | dmem_write;
  assign stall_cond = (dmem_any & dmem_wait) | muldiv_busy;

  // A stall cycle is a FETCH held by imem_wait (finish takes precedence) or a WAIT that persists.
  assign stall_cycle = ((state == FETCH) && !finish && imem_wait) ||
                       ((state == WAIT) && stall_cond);

  // Timeout fires on the stall cycle that would push the run past the limit.
  assign timeout = (WAIT_LIMIT != 0) && stall_cycle && (wait_cnt == 32'(WAIT_LIMIT));

  // Next-state and strobe decode from the current state and inputs.
  always_comb begin
    state_nxt   = state;
    imem_read_c = 1'b0;
    ir_load_c   = 1'b0;
    dmem_en_c   = 1'b0;
    commit_c    = 1'b0;
    case (state)
      FETCH: begin
        if (finish) begin
          state_nxt = HALT;
        end else begin
          imem_read_c = 1'b1;
          if (!imem_wait) begin
            ir_load_c = 1'b1;
            state_nxt = EXEC;
          end
        end
      end
      EXEC, WAIT: begin
        dmem_en_c = dmem_any;
        if (stall_cond) begin
          state_nxt = WAIT;
        end else begin
          commit_c  = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = HALT;
    endcase
    if (timeout) begin
      state_nxt = HALT;
    end
  end

  // State register and sticky bus error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      bus_error_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  // While reset is high every output is forced low.
  assign imem_read    = imem_read_c & ~reset;
  assign ir_load      = ir_load_c & ~reset;
  assign dmem_en      = dmem_en_c & ~reset;
  assign commit       = commit_c & ~reset;
  assign reg_write_en = commit_c & ctrl_reg_write & ~reset;
  assign active       = (state != HALT) & ~reset;
  assign bus_error    = bus_error_q & ~reset;

  sat_counter #(.W(32)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_cycle),
    .clr   (~stall_cycle),
    .count (wait_cnt)
  );

  sat_counter #(.W(32)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (active),
    .clr   (1'b0),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        finish = 1'b0;
  logic        imem_wait = 1'b0;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic        dmem_wait = 1'b0;
  logic        muldiv_busy = 1'b0;
  logic        ctrl_reg_write = 1'b0;
  logic        imem_read;
  logic        ir_load;
  logic        dmem_en;
  logic        commit;
  logic        reg_write_en;
  logic        active;
  logic        bus_error;
  logic [31:0] cycle_count;

  int errs = 0;
  int checks = 0;

  exec_sequencer #(.WAIT_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .finish         (finish),
    .imem_wait      (imem_wait),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_wait      (dmem_wait),
    .muldiv_busy    (muldiv_busy),
    .ctrl_reg_write (ctrl_reg_write),
    .imem_read      (imem_read),
    .ir_load        (ir_load),
    .dmem_en        (dmem_en),
    .commit         (commit),
    .reg_write_en   (reg_write_en),
    .active         (active),
    .bus_error      (bus_error),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: an instruction is either being fetched or in flight;
  // m_age counts cycles since ir_load, m_run is the current stall run length.
  logic        m_halt = 1'b0;
  logic        m_inflt = 1'b0;
  int          m_age = 0;
  int          m_run = 0;
  logic        m_berr = 1'b0;
  logic [31:0] m_cc = 32'd0;

  task automatic model_stall();
    if (m_run == int'(LIMIT)) begin
      m_halt = 1'b1;
      m_berr = 1'b1;
    end else begin
      m_run++;
    end
  endtask

  always @(negedge clk) begin
    logic e_im, e_ir, e_de, e_cm, e_rw, e_act, e_be;
    logic [31:0] e_cc;
    logic [38:0] exp_v, got_v;
    e_im = 0; e_ir = 0; e_de = 0; e_cm = 0; e_rw = 0; e_act = 0; e_be = 0;
    e_cc = 32'd0;
    if (reset) begin
      m_halt = 0; m_inflt = 0; m_age = 0; m_run = 0; m_berr = 0; m_cc = 32'd0;
    end else begin
      e_be = m_berr;
      e_cc = m_cc;
      if (!m_halt) begin
        e_act = 1'b1;
        if (m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 32'd1;
        if (!m_inflt) begin
          if (finish) begin
            m_halt = 1'b1;
          end else begin
            e_im = 1'b1;
            if (imem_wait) begin
              model_stall();
            end else begin
              e_ir = 1'b1;
              m_inflt = 1'b1;
              m_age = 0;
              m_run = 0;
            end
          end
        end else begin
          e_de = dmem_read | dmem_write;
          if ((e_de && dmem_wait) || muldiv_busy) begin
            // The first execute cycle is not itself a counted stall.
            if (m_age > 0) model_stall();
            m_age++;
          end else begin
            e_cm = 1'b1;
            e_rw = ctrl_reg_write;
            m_inflt = 1'b0;
            m_run = 0;
          end
        end
      end
    end
    exp_v = {e_im, e_ir, e_de, e_cm, e_rw, e_act, e_be, e_cc};
    got_v = {imem_read, ir_load, dmem_en, commit, reg_write_en, active, bus_error, cycle_count};
    checks++;
    if (got_v !== exp_v) begin
      errs++;
      $display("FAIL model_cycle t=%0t: got {ir,ld,de,cm,rw,act,be,cc}=%b_%h required %b_%h",
               $time, got_v[38:32], got_v[31:0], exp_v[38:32], exp_v[31:0]);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fi, input logic iw, input logic dr, input logic dw,
                       input logic dwt, input logic mb, input logic crw);
    finish = fi; imem_wait = iw; dmem_read = dr; dmem_write = dw;
    dmem_wait = dwt; muldiv_busy = mb; ctrl_reg_write = crw;
  endtask

  initial begin
    int burst;
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("rst_imem_read", 32'(imem_read), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    nxt(); nxt();
    reset = 1'b0;
    // Back-to-back instructions, no waits.
    @(negedge clk);
    chk("c1_imem_read", 32'(imem_read), 32'd1);
    chk("c1_ir_load", 32'(ir_load), 32'd1);
    chk("c1_commit", 32'(commit), 32'd0);
    nxt(); @(negedge clk);
    chk("c2_commit", 32'(commit), 32'd1);
    chk("c2_reg_write_en", 32'(reg_write_en), 32'd1);
    chk("c2_cycle_count", cycle_count, 32'd1);
    // imem_wait for 3 cycles.
    nxt(); drive(0, 1, 0, 0, 0, 0, 1); @(negedge clk);
    chk("iw_ir_load_held", 32'(ir_load), 32'd0);
    nxt(); nxt(); nxt(); drive(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("iw_ir_load_4th", 32'(ir_load), 32'd1);
    nxt(); @(negedge clk);
    chk("iw_commit", 32'(commit), 32'd1);
    // Load with two dmem_wait cycles.
    nxt(); @(negedge clk);
    chk("ld_fetch", 32'(ir_load), 32'd1);
    nxt(); drive(0, 0, 1, 0, 1, 0, 1); @(negedge clk);
    chk("ld_dmem_en", 32'(dmem_en), 32'd1);
    chk("ld_exec_commit", 32'(commit), 32'd0);
    nxt(); @(negedge clk);
    chk("ld_wait1_commit", 32'(commit), 32'd0);
    nxt(); drive(0, 0, 1, 0, 0, 0, 1); @(negedge clk);
    chk("ld_wait2_commit", 32'(commit), 32'd1);
    chk("ld_cycle_count", cycle_count, 32'd10);
    // finish on entering FETCH.
    nxt(); drive(1, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("fin_imem_read", 32'(imem_read), 32'd0);
    nxt(); @(negedge clk);
    chk("halt_active", 32'(active), 32'd0);
    chk("halt_cc", cycle_count, 32'd12);
    nxt(); @(negedge clk);
    chk("halt_cc_frozen", cycle_count, 32'd12);
    chk("halt_imem_read", 32'(imem_read), 32'd0);
    nxt(); reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("rst2_cc", cycle_count, 32'd0);
    nxt(); reset = 1'b0; @(negedge clk);
    chk("rst2_imem_read", 32'(imem_read), 32'd1);
    // Muldiv stuck: timeout after 5 WAIT cycles.
    nxt(); drive(0, 0, 0, 0, 0, 1, 1); @(negedge clk);
    chk("to_exec_commit", 32'(commit), 32'd0);
    for (int k = 0; k < 5; k++) begin
      nxt(); @(negedge clk);
      chk("to_wait_commit", 32'(commit), 32'd0);
      chk("to_wait_berr", 32'(bus_error), 32'd0);
    end
    nxt(); @(negedge clk);
    chk("to_halt_active", 32'(active), 32'd0);
    chk("to_bus_error", 32'(bus_error), 32'd1);
    nxt(); drive(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("to_bus_error_sticky", 32'(bus_error), 32'd1);
    // Reset during WAIT abandons the instruction.
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    nxt(); drive(0, 0, 0, 0, 0, 1, 1);
    nxt(); @(negedge clk);
    chk("rw_wait_commit", 32'(commit), 32'd0);
    nxt(); reset = 1'b1; drive(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("rw_commit", 32'(commit), 32'd0);
    chk("rw_reg_write_en", 32'(reg_write_en), 32'd0);
    nxt(); reset = 1'b0; @(negedge clk);
    chk("rw_refetch", 32'(ir_load), 32'd1);
    chk("rw_cc", cycle_count, 32'd0);
    // Randomized traffic with stall bursts, occasional finish and reset.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      nxt();
      if ((i % 100) == 0) burst = ($urandom_range(0, 2) == 0) ? 70 : 25;
      reset          = ($urandom_range(0, 99) < 2);
      finish         = ($urandom_range(0, 59) == 0);
      imem_wait      = ($urandom_range(0, 99) < burst);
      dmem_read      = ($urandom_range(0, 99) < 30);
      dmem_write     = ($urandom_range(0, 99) < 20);
      dmem_wait      = ($urandom_range(0, 99) < burst + 10);
      muldiv_busy    = ($urandom_range(0, 99) < burst);
      ctrl_reg_write = $urandom_range(0, 1) == 1;
    end
    nxt();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
